// File: rtl/mem_sram_bridge.sv
//==============================================================================
// Module   : mem_sram_bridge
// Purpose  : M-stage byte-enable access to SRAM-like req/addr_ok/data_ok bus.
//            Optional kseg0/kseg1 address folding: define BRIDGE_ADDR_MAP_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_sram_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addrM,
  input  logic [3:0]        readEnM,
  input  logic [3:0]        writeEnM,
  input  logic [DATA_W-1:0] wdataM,
  input  logic              flushM,
  input  logic              pipe_stall,
  output logic [DATA_W-1:0] rdataM,
  output logic              stallreq,
  output logic              req,
  output logic              wr,
  output logic [3:0]        wstrb,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_DONE    = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] c_ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t              r_state;
  state_t              w_nextState;
  logic [DATA_W-1:0]   r_heldData;
  logic                w_access;
  logic                w_isWrite;
  logic                w_req;
  logic                w_stall;
  logic                w_capture;
  logic [ADDR_W-1:0]   w_mappedAddr;

  assign w_isWrite = |writeEnM;
  assign w_access  = w_isWrite | (|readEnM);

`ifdef BRIDGE_ADDR_MAP_EN
  // kseg0/kseg1 (top bits 2'b10) fold onto the physical low 512 MB
  localparam logic [ADDR_W-1:0] c_SEG_MASK = {3'b111, {(ADDR_W-3){1'b0}}};
  logic w_kseg;
  assign w_kseg       = (addrM[ADDR_W-1 -: 2] == 2'b10);
  assign w_mappedAddr = w_kseg ? (addrM & ~c_SEG_MASK) : addrM;
`else
  assign w_mappedAddr = addrM;
`endif

  // Bus fields follow the M-stage inputs, which the stall keeps frozen in REQ
  assign wr    = w_isWrite;
  assign wstrb = w_isWrite ? writeEnM : readEnM;
  assign addr  = w_mappedAddr & c_ALIGN_MASK;
  assign wdata = wdataM;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_heldData <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_capture) r_heldData <= rdata;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access && !flushM) begin
          w_req       = 1'b1;
          w_stall     = 1'b1;
          w_nextState = addr_ok ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
        if (addr_ok)     w_nextState = flushM ? S_DISCARD : S_WAIT;
        else if (flushM) w_nextState = S_IDLE;
      end
      S_WAIT: begin
        if (data_ok) begin
          // A flush in the data_ok cycle wins: the word is never delivered
          w_capture = !flushM;
          if (flushM)          w_nextState = S_IDLE;
          else if (pipe_stall) w_nextState = S_DONE;
          else                 w_nextState = S_IDLE;
        end else begin
          w_stall = 1'b1;
          if (flushM) w_nextState = S_DISCARD;
        end
      end
      S_DONE: begin
        if (!pipe_stall || flushM) w_nextState = S_IDLE;
      end
      S_DISCARD: begin
        w_stall = w_access;
        if (data_ok) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  assign req      = rst & w_req;
  assign stallreq = rst & w_stall;
  assign rdataM   = (r_state == S_WAIT && data_ok) ? rdata : r_heldData;

endmodule

`default_nettype wire

// File: tb/tb_mem_sram_bridge.sv
//==============================================================================
// Module   : tb_mem_sram_bridge
// Purpose  : Scoreboard bench for mem_sram_bridge (directed vectors).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addrM;
  logic [3:0]  readEnM, writeEnM;
  logic [31:0] wdataM;
  logic        flushM, pipe_stall;
  logic [31:0] rdataM;
  logic        stallreq, req, wr;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  mem_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .addrM(addrM), .readEnM(readEnM), .writeEnM(writeEnM),
    .wdataM(wdataM), .flushM(flushM), .pipe_stall(pipe_stall), .rdataM(rdataM),
    .stallreq(stallreq), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } busExp_t;

  busExp_t     reqQ[$];
  logic [31:0] rdQ[$];
  logic        expectData = 1'b0;
  int          nCmp = 0;
  int          nErr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pushReq(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    busExp_t e;
    e.wr = w; e.addr = a; e.wstrb = s; e.wdata = d;
    reqQ.push_back(e);
  endtask

  // Monitor: bus request fields while req is up, load data on delivery cycles
  always @(negedge clk) begin
    if (rst) begin
      if (req) begin
        if (reqQ.size() == 0) begin
          check("unexpected_req", {31'b0, req}, 32'h0);
        end else begin
          check("bus_wr",    {31'b0, wr},    {31'b0, reqQ[0].wr});
          check("bus_addr",  addr,           reqQ[0].addr);
          check("bus_wstrb", {28'b0, wstrb}, {28'b0, reqQ[0].wstrb});
          check("bus_wdata", wdata,          reqQ[0].wdata);
          if (addr_ok) void'(reqQ.pop_front());
        end
      end
      if (expectData) begin
        if (rdQ.size() == 0) check("rdataM_unexpected", rdataM, 32'hx);
        else                 check("rdataM", rdataM, rdQ.pop_front());
      end
    end
  end

  // One access through the bus; caller sits at posedge+1
  task automatic doAccess(input string name, input logic [31:0] a, input logic [3:0] rEn,
                          input logic [3:0] wEn, input logic [31:0] wd,
                          input logic expWr, input logic [31:0] expAddr, input logic [3:0] expStrb,
                          input int aDelay, input int dDelay, input logic [31:0] rd,
                          input int expStalls);
    int stalls = 0;
    addrM = a; readEnM = rEn; writeEnM = wEn; wdataM = wd;
    pushReq(expWr, expAddr, expStrb, wd);
    if (!expWr) rdQ.push_back(rd);
    for (int c = 0; c <= aDelay + 1 + dDelay; c++) begin
      addr_ok    = (c == aDelay);
      data_ok    = (c == aDelay + 1 + dDelay);
      rdata      = data_ok ? rd : 32'h0BAD_0BAD;
      expectData = data_ok && !expWr;
      @(negedge clk);
      if (stallreq) stalls++;
      @(posedge clk); #1;
    end
    addr_ok = 0; data_ok = 0; expectData = 0;
    readEnM = 0; writeEnM = 0; wdataM = 0;
    check({name, "_stalls"}, stalls, expStalls);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] mapExp;
`ifdef BRIDGE_ADDR_MAP_EN
    mapExp = 32'h1FC0_0004;
`else
    mapExp = 32'hBFC0_0004;
`endif
    rst = 0; addrM = 32'h10; readEnM = 4'hF; writeEnM = 0; wdataM = 0;
    flushM = 0; pipe_stall = 0; addr_ok = 0; data_ok = 0; rdata = 0;

    // Reset state with an access already presented
    @(negedge clk);
    check("rst_req",      {31'b0, req},      32'h0);
    check("rst_stallreq", {31'b0, stallreq}, 32'h0);
    check("rst_rdataM",   rdataM,            32'h0);
    @(posedge clk); #1;
    rst = 1; readEnM = 0; addrM = 0;
    @(posedge clk); #1;

    // Minimum-latency load
    doAccess("load_min", 32'h10, 4'hF, 4'h0, 32'h0, 1'b0, 32'h10, 4'hF, 0, 0, 32'hDEAD_BEEF, 1);
    // Store with addr_ok 3 cycles late, unaligned address
    doAccess("store_slow", 32'h22, 4'h0, 4'b1100, 32'hABCD_0000, 1'b1, 32'h20, 4'b1100, 3, 0, 32'h0, 4);
    // Byte load with slow data_ok
    doAccess("byte_load", 32'h1003, 4'b1000, 4'h0, 32'h0, 1'b0, 32'h1000, 4'b1000, 0, 2, 32'h8800_0000, 3);
    // Both enables: store wins
    doAccess("both_en", 32'h2000, 4'hF, 4'b0011, 32'h0000_1234, 1'b1, 32'h2000, 4'b0011, 0, 0, 32'h0, 1);

    // Flushed access in IDLE issues nothing
    addrM = 32'h30; readEnM = 4'hF; flushM = 1;
    @(negedge clk);
    check("idle_flush_stallreq", {31'b0, stallreq}, 32'h0);
    @(posedge clk); #1;
    flushM = 0; readEnM = 0;

    // Completion under pipe_stall: DONE holds data, no new req
    addrM = 32'h50; readEnM = 4'hF; addr_ok = 1;
    pushReq(1'b0, 32'h50, 4'hF, 32'h0);
    rdQ.push_back(32'h1234_5678);
    @(negedge clk);
    check("done_issue_stall", {31'b0, stallreq}, 32'h1);
    @(posedge clk); #1;
    addr_ok = 0; data_ok = 1; rdata = 32'h1234_5678; pipe_stall = 1; expectData = 1;
    @(negedge clk);
    check("done_dataok_stall", {31'b0, stallreq}, 32'h0);
    @(posedge clk); #1;
    data_ok = 0; expectData = 0; rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) pipe_stall = 0;
      @(negedge clk);
      check("done_hold_rdataM", rdataM, 32'h1234_5678);
      check("done_stallreq", {31'b0, stallreq}, 32'h0);
      @(posedge clk); #1;
    end
    readEnM = 0; addrM = 0;

    // Flush in WAIT before data_ok, then next access waits in DISCARD
    addrM = 32'h40; readEnM = 4'hF; addr_ok = 1;
    pushReq(1'b0, 32'h40, 4'hF, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    addr_ok = 0; flushM = 1;
    @(negedge clk);
    check("wait_flush_stallreq", {31'b0, stallreq}, 32'h1);
    @(posedge clk); #1;
    flushM = 0; addrM = 32'h44; readEnM = 4'b0011;
    @(negedge clk);
    check("discard_stallreq", {31'b0, stallreq}, 32'h1);
    @(posedge clk); #1;
    data_ok = 1; rdata = 32'h5555_5555;
    @(negedge clk);
    check("discard_dataok_stallreq", {31'b0, stallreq}, 32'h1);
    @(posedge clk); #1;
    data_ok = 0;
    doAccess("after_discard", 32'h44, 4'b0011, 4'h0, 32'h0, 1'b0, 32'h44, 4'b0011, 0, 0, 32'hCAFE_F00D, 1);

    // data_ok with flush: not delivered, back to IDLE (not DISCARD)
    addrM = 32'h60; readEnM = 4'hF; addr_ok = 1;
    pushReq(1'b0, 32'h60, 4'hF, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    addr_ok = 0; data_ok = 1; rdata = 32'h7777_7777; flushM = 1;
    @(negedge clk);
    check("flush_dataok_stallreq", {31'b0, stallreq}, 32'h0);
    @(posedge clk); #1;
    data_ok = 0; flushM = 0;
    doAccess("after_flush_data", 32'h64, 4'hF, 4'h0, 32'h0, 1'b0, 32'h64, 4'hF, 0, 0, 32'h0101_0202, 1);

    // Reset while a read is outstanding
    addrM = 32'h80; readEnM = 4'hF; addr_ok = 1;
    pushReq(1'b0, 32'h80, 4'hF, 32'h0);
    @(negedge clk);
    check("held_before_reset", rdataM, 32'h0101_0202);
    @(posedge clk); #1;
    addr_ok = 0; rst = 0;
    #1;
    check("wait_rst_req",      {31'b0, req},      32'h0);
    check("wait_rst_stallreq", {31'b0, stallreq}, 32'h0);
    check("wait_rst_rdataM",   rdataM,            32'h0);
    @(posedge clk); #1;
    rst = 1; readEnM = 0; addrM = 0;
    @(posedge clk); #1;
    doAccess("post_reset", 32'h84, 4'hF, 4'h0, 32'h0, 1'b0, 32'h84, 4'hF, 1, 2, 32'h0F0F_0F0F, 4);

    // Address map: kseg1 address
    doAccess("addr_map", 32'hBFC0_0004, 4'hF, 4'h0, 32'h0, 1'b0, mapExp, 4'hF, 0, 0, 32'h3C1C_0001, 1);

    repeat (3) @(posedge clk);
    check("reqQ_drained", reqQ.size(), 32'h0);
    check("rdQ_drained",  rdQ.size(),  32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

`default_nettype wire
